// File: rtl/or_1bit_vector_sequencer_if.sv
// Handshake/bus bundle between the OR-fabric sequencer and the environment around it.
// The sequencer takes the master modport; the side that hosts the mapped DUT takes the slave modport.
interface or_1bit_vector_sequencer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic             dut_a;
  logic             dut_b;
  logic             dut_c;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_idx;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] first_fail_idx;

  modport master (
    input  start,
    input  dut_c,
    output dut_a,
    output dut_b,
    output busy,
    output done,
    output pass,
    output vec_idx,
    output pass_cnt,
    output fail_cnt,
    output first_fail_idx
  );

  modport slave (
    output start,
    output dut_c,
    input  dut_a,
    input  dut_b,
    input  busy,
    input  done,
    input  pass,
    input  vec_idx,
    input  pass_cnt,
    input  fail_cnt,
    input  first_fail_idx
  );
endinterface

// File: rtl/or_1bit_vector_sequencer.sv
// Self-checking stimulus sequencer for a 1-bit OR fabric: drives a/b, waits a settle
// window, compares c against a|b and keeps a pass/fail tally with a final verdict.
module or_1bit_vector_sequencer #(
  parameter int unsigned NUM_VECTORS   = 6,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned WARMUP_CYCLES = 10,
  parameter int unsigned CNT_W         = 8
) (
  input logic                        clk,
  input logic                        rst,
  or_1bit_vector_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    DRIVE,
    SETTLE,
    CHECK,
    COOLDOWN,
    DONE
  } state_e;

  localparam int unsigned CYC_W = 8;
  localparam logic [CYC_W-1:0] WARM_LAST   =
    CYC_W'((WARMUP_CYCLES == 0) ? 0 : WARMUP_CYCLES - 1);
  localparam logic [CYC_W-1:0] SETTLE_LAST =
    CYC_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] NO_FAIL     = '1;
  localparam logic [CNT_W-1:0] TABLE_LEN   = CNT_W'(6);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CYC_W-1:0] CYC_ONE     = CYC_W'(1);

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;

  logic             start_ok_c;
  logic             mismatch_c;
  logic [1:0]       entry_c;

  // Six-entry operand table {a,b}; longer runs wrap around it.
  function automatic logic [1:0] vec_entry(input logic [CNT_W-1:0] idx);
    logic [CNT_W-1:0] m;
    m = idx % TABLE_LEN;
    case (m[2:0])
      3'd0:    vec_entry = 2'b00;
      3'd1:    vec_entry = 2'b01;
      3'd2:    vec_entry = 2'b10;
      3'd3:    vec_entry = 2'b11;
      3'd4:    vec_entry = 2'b01;
      default: vec_entry = 2'b10;
    endcase
  endfunction

  assign entry_c = vec_entry(vec_q);

  // Case-inequality so an X/Z from the fabric is a mismatch in simulation.
  assign mismatch_c = (bus.dut_c !== (a_q | b_q));

  // In DONE a new run is only taken once the verdict has been published.
  assign start_ok_c = bus.start &&
                      ((state_q == IDLE) || ((state_q == DONE) && done_q));

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = done_q;
    pass_d  = pass_q;
    vec_d   = vec_q;
    pcnt_d  = pcnt_q;
    fcnt_d  = fcnt_q;
    ffi_d   = ffi_q;

    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && !done_q) begin
          done_d = 1'b1;
          pass_d = (fcnt_q == '0);
        end
        if (start_ok_c) begin
          cyc_d   = '0;
          vec_d   = '0;
          pcnt_d  = '0;
          fcnt_d  = '0;
          ffi_d   = NO_FAIL;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          state_d = (WARMUP_CYCLES == 0) ? DRIVE : WARMUP;
        end
      end

      WARMUP: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (cyc_q == WARM_LAST) begin
          cyc_d   = '0;
          state_d = DRIVE;
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end

      DRIVE: begin
        a_d     = entry_c[1];
        b_d     = entry_c[0];
        cyc_d   = '0;
        state_d = SETTLE;
      end

      SETTLE: begin
        if (cyc_q == SETTLE_LAST) begin
          cyc_d   = '0;
          state_d = CHECK;
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end

      CHECK: begin
        if (mismatch_c) begin
          fcnt_d = fcnt_q + ONE;
          if (fcnt_q == '0) begin
            ffi_d = vec_q;
          end
        end else begin
          pcnt_d = pcnt_q + ONE;
        end
        cyc_d = '0;
        if (vec_q == LAST_IDX) begin
          state_d = (WARMUP_CYCLES == 0) ? DONE : COOLDOWN;
        end else begin
          vec_d   = vec_q + ONE;
          state_d = DRIVE;
        end
      end

      COOLDOWN: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (cyc_q == WARM_LAST) begin
          cyc_d   = '0;
          state_d = DONE;
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      vec_q   <= '0;
      pcnt_q  <= '0;
      fcnt_q  <= '0;
      ffi_q   <= NO_FAIL;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      vec_q   <= vec_d;
      pcnt_q  <= pcnt_d;
      fcnt_q  <= fcnt_d;
      ffi_q   <= ffi_d;
    end
  end

  assign bus.dut_a          = a_q;
  assign bus.dut_b          = b_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.vec_idx        = vec_q;
  assign bus.pass_cnt       = pcnt_q;
  assign bus.fail_cnt       = fcnt_q;
  assign bus.first_fail_idx = ffi_q;

endmodule
